// File: rtl/frame_tx_fifo_pkg.sv
// Shared types for frame_tx_fifo: read-side FSM states and counter widths.
package frame_tx_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } rd_state_t;

  // Sized for the largest legal DEPTH (65536 -> 17-bit length) and IFG (255).
  localparam int LEN_W = 17;
  localparam int IFG_W = 8;

  typedef logic [LEN_W-1:0] len_cnt_t;
  typedef logic [IFG_W-1:0] ifg_cnt_t;

endpackage

// File: rtl/frame_tx_fifo_ram.sv
// Simple dual-port byte RAM, one write port and one registered read port.
module frame_tx_fifo_ram #(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/frame_tx_fifo.sv
// Store-and-forward frame FIFO: whole frames in, IFG-spaced frames out.
// Define FRAME_TX_FIFO_STATS_EN to add frames_sent/frames_dropped counters.
module frame_tx_fifo #(
  parameter int DEPTH      = 2048,
  parameter int MAX_FRAMES = 8,
  parameter int IFG        = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        vin,
  output logic        full,
  output logic        drop,
  output logic [7:0]  dout,
  output logic        vout
`ifdef FRAME_TX_FIFO_STATS_EN
  ,
  output logic [31:0] frames_sent,
  output logic [15:0] frames_dropped
`endif
);
  import frame_tx_fifo_pkg::*;

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int DW  = $clog2(MAX_FRAMES);
  localparam int DCW = DW + 1;
  localparam len_cnt_t DEPTH_L = len_cnt_t'(DEPTH);

  // Write side: r_wr_ptr is the committed end; in-progress bytes sit at r_wr_ptr + r_len.
  logic [AW-1:0] r_wr_ptr;
  len_cnt_t      r_len;
  logic          r_in_frame;
  logic          r_discard;
  len_cnt_t      r_cnt;

  logic [LW-1:0]  r_desc [MAX_FRAMES];
  logic [DW-1:0]  r_dwr;
  logic [DW-1:0]  r_drd;
  logic [DCW-1:0] r_dcnt;

  rd_state_t     r_state;
  logic [AW-1:0] r_rd_ptr;
  len_cnt_t      r_rem;
  ifg_cnt_t      r_gap;
  logic          r_vout;

  logic          w_pop;
  logic          w_push;
  logic          w_full;
  logic          w_room;
  logic          w_wr_en;
  logic          w_rd_en;
  logic [AW-1:0] w_waddr;
  logic [7:0]    w_rdata;

  assign w_pop   = (r_state == ST_IDLE) && (r_dcnt != '0);
  assign w_rd_en = (r_state == ST_SEND);
  // A pop this cycle frees a slot for a frame starting this cycle.
  assign w_full  = (r_dcnt == DCW'(MAX_FRAMES)) && !w_pop;
  assign w_room  = (r_cnt + r_len) < DEPTH_L;
  assign w_wr_en = vin && !r_discard && w_room && (r_in_frame || !w_full);
  assign w_push  = !vin && r_in_frame;
  assign w_waddr = r_wr_ptr + r_len[AW-1:0];

  assign full = w_full;
  assign drop = r_discard && !vin;
  assign vout = r_vout;
  assign dout = r_vout ? w_rdata : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_len      <= '0;
      r_in_frame <= 1'b0;
      r_discard  <= 1'b0;
    end else if (vin) begin
      if (w_wr_en) begin
        r_len      <= r_len + len_cnt_t'(1);
        r_in_frame <= 1'b1;
      end else if (!r_discard) begin
        // Started while full, or ran out of room: rewind and swallow the rest.
        r_discard  <= 1'b1;
        r_in_frame <= 1'b0;
        r_len      <= '0;
      end
    end else begin
      if (r_in_frame) begin
        r_wr_ptr   <= r_wr_ptr + r_len[AW-1:0];
        r_len      <= '0;
        r_in_frame <= 1'b0;
      end
      r_discard <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dwr  <= '0;
      r_drd  <= '0;
      r_dcnt <= '0;
    end else begin
      if (w_push) begin
        r_desc[r_dwr] <= r_len[LW-1:0];
        r_dwr         <= r_dwr + DW'(1);
      end
      if (w_pop) r_drd <= r_drd + DW'(1);
      case ({w_push, w_pop})
        2'b10:   r_dcnt <= r_dcnt + DCW'(1);
        2'b01:   r_dcnt <= r_dcnt - DCW'(1);
        default: r_dcnt <= r_dcnt;
      endcase
    end
  end

  // Committed-but-unread byte count; bounds the space check on the write side.
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= r_cnt + (w_push ? r_len : '0) - (w_rd_en ? len_cnt_t'(1) : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_rd_ptr <= '0;
      r_rem    <= '0;
      r_gap    <= '0;
      r_vout   <= 1'b0;
    end else begin
      r_vout <= w_rd_en;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_rem   <= len_cnt_t'(r_desc[r_drd]);
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
          r_rem    <= r_rem - len_cnt_t'(1);
          if (r_rem == len_cnt_t'(1)) begin
            r_gap   <= ifg_cnt_t'(IFG);
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_gap == ifg_cnt_t'(1)) r_state <= ST_IDLE;
          else                        r_gap   <= r_gap - ifg_cnt_t'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  frame_tx_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (w_waddr),
    .i_wdata (din),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

`ifdef FRAME_TX_FIFO_STATS_EN
  logic [31:0] r_sent;
  logic [15:0] r_dropped;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sent    <= '0;
      r_dropped <= '0;
    end else begin
      if (w_rd_en && (r_rem == len_cnt_t'(1))) r_sent <= r_sent + 32'd1;
      if (drop) r_dropped <= r_dropped + 16'd1;
    end
  end

  assign frames_sent    = r_sent;
  assign frames_dropped = r_dropped;
`endif

endmodule

// File: doc/frame_tx_fifo.md
FRAME_TX_FIFO -- requirements
Module: frame_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 2048, data buffer size in bytes, power of two, 16..65536.
REQ-002 SHALL have parameter MAX_FRAMES, default 8, frame descriptor slots, power of two, 2..64.
REQ-003 SHALL have parameter IFG, default 12, minimum idle cycles between output frames, 1..255.
REQ-004 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port din  input  8  write byte.
REQ-007 SHALL have port vin  input  1  write valid; frame = contiguous run of vin=1 cycles, ends on first vin=0 cycle.
REQ-008 SHALL have port full  output  1  no descriptor slot free; a frame started now is dropped.
REQ-009 SHALL have port drop  output  1  one-cycle pulse: frame discarded.
REQ-010 SHALL have port dout  output  8  read byte.
REQ-011 SHALL have port vout  output  1  read valid; high for exactly frame-length consecutive cycles per frame.

Function
REQ-012 SHALL store frames whole and emit only committed frames, never a partial one.
REQ-013 SHALL commit a frame in the first vin=0 cycle after a run: push length (width $clog2(DEPTH)+1) into descriptor FIFO.
REQ-014 SHALL drop the whole frame if, at its first byte, full=1; ignore remaining bytes until vin=0.
REQ-015 SHALL drop the whole frame if stored bytes plus in-progress bytes would exceed DEPTH; rewind write pointer to frame start; ignore bytes until vin=0.
REQ-016 SHALL pulse drop for one cycle, in the first vin=0 cycle, for each dropped frame; no descriptor pushed.
REQ-017 SHALL run read FSM IDLE -> SEND -> GAP -> IDLE.
REQ-018 IDLE: SHALL go to SEND when descriptor FIFO non-empty; pop descriptor.
REQ-019 SHALL deliver the first byte with vout=1 exactly 3 cycles after the commit cycle when FSM is IDLE (commit cycle = cycle 0).
REQ-020 SEND: SHALL keep vout=1 with no bubbles for the descriptor length, then enter GAP.
REQ-021 GAP: SHALL hold vout=0 for exactly IFG cycles, then return to IDLE; back-to-back frames separated by IFG+1 idle cycles after IDLE evaluation.
REQ-022 SHALL wrap read and write pointers modulo DEPTH; a frame crossing the buffer end SHALL be emitted in order.
REQ-023 SHALL allow simultaneous write commit and read pop in the same cycle with no loss; full reflects the pop the same cycle.
REQ-024 SHALL accept frames of 1..DEPTH bytes; a DEPTH-byte frame into an empty buffer SHALL be accepted.
REQ-025 SHALL hold dout at 0 whenever vout=0.

Reset
REQ-026 SHALL, on rst=1, clear pointers, descriptor FIFO, in-progress frame and FSM (IDLE); discard all stored data.
REQ-027 SHALL drive vout=0, dout=0, drop=0, full=0 in the cycle after rst sampled high, including mid-SEND.
REQ-028 SHALL treat vin=1 in the first cycle after reset release as a new frame start.

Configuration
REQ-029 With FRAME_TX_FIFO_STATS_EN defined SHALL add outputs frames_sent[31:0] (increment at last byte of each frame) and frames_dropped[15:0] (increment with drop), both wrapping, cleared by rst.
REQ-030 Without FRAME_TX_FIFO_STATS_EN SHALL omit those ports and counters; all other behaviour identical.

Structure
REQ-031 SHALL place FSM state enum and IFG/length counter typedef widths in package frame_tx_fifo_pkg.
REQ-032 SHALL instantiate one sub-module frame_tx_fifo_ram: simple dual-port, DEPTH x 8, 1-cycle registered read.

Verification (DEPTH=64, MAX_FRAMES=4, IFG=12)
REQ-033 Single 10-byte frame 0x01..0x0A -> vout=1 for 10 consecutive cycles starting 3 cycles after commit, same bytes, drop=0.
REQ-034 Three 5-byte frames back-to-back with 1 idle cycle between -> three output frames, each separated by >=12 vout=0 cycles, contents intact.
REQ-035 70-byte frame into empty buffer -> drop pulse at first vin=0 cycle, no output; subsequent 4-byte frame emitted correctly.
REQ-036 Five 3-byte frames while output stalled by IFG -> full=1 after 4th commit; 5th frame dropped, 4 frames emitted.
REQ-037 Frames of 40 then 40 bytes (second wraps pointer) -> both emitted in order, byte-exact.
REQ-038 rst asserted mid-SEND of 20-byte frame -> vout=0 next cycle, no further output, next frame after release emitted correctly.
